// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared enumerations, flag indices and FSM state type for alu_seq
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_MUL   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_NOT   = 4'd6,
        OP_MOV   = 4'd7,
        OP_CMP   = 4'd8,
        OP_MOVI  = 4'd9,
        OP_TST   = 4'd10,
        OP_RSV11 = 4'd11,
        OP_RSV12 = 4'd12,
        OP_RSV13 = 4'd13,
        OP_RSV14 = 4'd14,
        OP_NOP   = 4'd15
    } opcode_e;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,
        CC_EQ = 4'd1,
        CC_NE = 4'd2,
        CC_CS = 4'd3,
        CC_CC = 4'd4,
        CC_MI = 4'd5,
        CC_PL = 4'd6,
        CC_VS = 4'd7,
        CC_VC = 4'd8,
        CC_HI = 4'd9,
        CC_LS = 4'd10,
        CC_GE = 4'd11,
        CC_LT = 4'd12,
        CC_GT = 4'd13,
        CC_LE = 4'd14,
        CC_NV = 4'd15
    } cond_e;

    typedef enum logic [2:0] {
        SR_NONE = 3'd0,
        SR_LSL  = 3'd1,
        SR_LSR  = 3'd2,
        SR_ASR  = 3'd3,
        SR_ROR  = 3'd4
    } srctrl_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational barrel shifter for operand 2 with shifter carry
// Ports: din/ctrl/shamt in; dout = shifted operand, cout = last bit shifted out,
// cvalid = cout is meaningful (non-zero amount and a real shift selected).
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [WIDTH-1:0]   din,
    input  logic [2:0]         ctrl,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   dout,
    output logic               cout,
    output logic               cvalid
);

    // One extra bit on the far side of each shift catches the last bit shifted out.
    logic [WIDTH:0]     lsl_ext;
    logic [WIDTH:0]     lsr_ext;
    logic [WIDTH:0]     asr_ext;
    logic [WIDTH-1:0]   ror_val;
    logic [SHAMT_W:0]   ror_back;

    assign lsl_ext  = {1'b0, din} << shamt;
    assign lsr_ext  = {din, 1'b0} >> shamt;
    assign asr_ext  = $signed({din, 1'b0}) >>> shamt;
    assign ror_back = (SHAMT_W+1)'(WIDTH) - {1'b0, shamt};
    assign ror_val  = (din >> shamt) | (din << ror_back);

    assign cvalid = (shamt != '0) &&
                    ((ctrl == SR_LSL) || (ctrl == SR_LSR) || (ctrl == SR_ASR) || (ctrl == SR_ROR));

    always_comb begin
        dout = din;
        cout = 1'b0;
        case (ctrl)
            SR_LSL: begin
                dout = lsl_ext[WIDTH-1:0];
                cout = lsl_ext[WIDTH];
            end
            SR_LSR: begin
                dout = lsr_ext[WIDTH:1];
                cout = lsr_ext[0];
            end
            SR_ASR: begin
                dout = asr_ext[WIDTH:1];
                cout = asr_ext[0];
            end
            SR_ROR: begin
                // The last bit rotated out lands in the msb.
                dout = ror_val;
                cout = ror_val[WIDTH-1];
            end
            default: begin
                dout = din;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with NZCV flags, condition codes, shifted operand 2 and iterative multiply
// Ports: clk, rst_n (async active-low); request in_valid/in_ready with opcode, cond, s,
// srctrl, shamt, in1, in2, imvalue; flags_wr/flags_wdata direct flag load; completion
// out_valid/out_we with registered result; flags {N,Z,C,V}; busy = ~in_ready.
// Build option: define ALU_MUL_EN to build the iterative multiplier (opcode 2); otherwise opcode 2 is a NOP.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [3:0]         cond,
    input  logic               s,
    input  logic [2:0]         srctrl,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [IMM_W-1:0]   imvalue,
    input  logic               flags_wr,
    input  logic [3:0]         flags_wdata,
    output logic               out_valid,
    output logic               out_we,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    output logic               busy
);

    logic [WIDTH-1:0] op2;
    logic             sh_c;
    logic             sh_cv;

    alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
        .din    (in2),
        .ctrl   (srctrl),
        .shamt  (shamt),
        .dout   (op2),
        .cout   (sh_c),
        .cvalid (sh_cv)
    );

    logic accept;
    logic cond_ok;
    logic op_is_seq;

    assign accept = in_valid & in_ready;
    assign busy   = ~in_ready;

    always_comb begin
        cond_ok = 1'b1;
        case (cond)
            CC_AL: cond_ok = 1'b1;
            CC_EQ: cond_ok = flags[FLAG_Z];
            CC_NE: cond_ok = ~flags[FLAG_Z];
            CC_CS: cond_ok = flags[FLAG_C];
            CC_CC: cond_ok = ~flags[FLAG_C];
            CC_MI: cond_ok = flags[FLAG_N];
            CC_PL: cond_ok = ~flags[FLAG_N];
            CC_VS: cond_ok = flags[FLAG_V];
            CC_VC: cond_ok = ~flags[FLAG_V];
            CC_HI: cond_ok = flags[FLAG_C] & ~flags[FLAG_Z];
            CC_LS: cond_ok = ~flags[FLAG_C] | flags[FLAG_Z];
            CC_GE: cond_ok = flags[FLAG_N] == flags[FLAG_V];
            CC_LT: cond_ok = flags[FLAG_N] != flags[FLAG_V];
            CC_GT: cond_ok = ~flags[FLAG_Z] & (flags[FLAG_N] == flags[FLAG_V]);
            CC_LE: cond_ok = flags[FLAG_Z] | (flags[FLAG_N] != flags[FLAG_V]);
            CC_NV: cond_ok = 1'b0;
            default: cond_ok = 1'b1;
        endcase
    end

    // Single-cycle datapath
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic             add_v;
    logic             sub_v;
    logic             c_keep;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             res_we;
    logic             flag_upd;
    logic [3:0]       new_flags;

    assign sum_ext = {1'b0, in1} + {1'b0, op2};
    assign dif_ext = {1'b0, in1} - {1'b0, op2};
    assign add_v   = (in1[WIDTH-1] == op2[WIDTH-1]) & (sum_ext[WIDTH-1] != in1[WIDTH-1]);
    assign sub_v   = (in1[WIDTH-1] != op2[WIDTH-1]) & (dif_ext[WIDTH-1] != in1[WIDTH-1]);
    assign c_keep  = sh_cv ? sh_c : flags[FLAG_C];

    always_comb begin
        alu_res  = '0;
        alu_c    = flags[FLAG_C];
        alu_v    = flags[FLAG_V];
        res_we   = 1'b0;
        flag_upd = s;
        case (opcode)
            OP_ADD:  begin alu_res = sum_ext[WIDTH-1:0]; alu_c = sum_ext[WIDTH];  alu_v = add_v; res_we = 1'b1; end
            OP_SUB:  begin alu_res = dif_ext[WIDTH-1:0]; alu_c = ~dif_ext[WIDTH]; alu_v = sub_v; res_we = 1'b1; end
            OP_AND:  begin alu_res = in1 & op2; alu_c = c_keep; res_we = 1'b1; end
            OP_OR:   begin alu_res = in1 | op2; alu_c = c_keep; res_we = 1'b1; end
            OP_XOR:  begin alu_res = in1 ^ op2; alu_c = c_keep; res_we = 1'b1; end
            OP_NOT:  begin alu_res = ~op2;      alu_c = c_keep; res_we = 1'b1; end
            OP_MOV:  begin alu_res = op2;       alu_c = c_keep; res_we = 1'b1; end
            OP_CMP:  begin alu_res = dif_ext[WIDTH-1:0]; alu_c = ~dif_ext[WIDTH]; alu_v = sub_v; flag_upd = 1'b1; end
            OP_MOVI: begin alu_res = WIDTH'(imvalue); res_we = 1'b1; end
            OP_TST:  begin alu_res = in1 & op2; alu_c = c_keep; flag_upd = 1'b1; end
            // MUL completes through the FSM; reserved opcodes and NOP touch nothing.
            default: flag_upd = 1'b0;
        endcase
    end

    assign new_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};

`ifdef ALU_MUL_EN
    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_step;
    logic [SHAMT_W-1:0] cnt_q;
    logic               ms_q;
    logic               mul_start;
    logic               mul_last;

    assign op_is_seq = (opcode == OP_MUL);
    assign mul_start = accept & cond_ok & op_is_seq;
    assign mul_last  = (state_q == ST_MUL) && (cnt_q == '0);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign in_ready  = (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mul_start) state_d = ST_MUL;
            ST_MUL:  if (cnt_q == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the low WIDTH product bits are kept, so the accumulator never needs to widen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ms_q     <= 1'b0;
        end else if (mul_start) begin
            mcand_q  <= in1;
            mplier_q <= op2;
            acc_q    <= '0;
            cnt_q    <= SHAMT_W'(WIDTH - 1);
            ms_q     <= s;
        end else if (state_q == ST_MUL) begin
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
        end
    end
`else
    assign op_is_seq = 1'b0;
    assign in_ready  = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            out_we    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_we    <= 1'b0;
            if (accept) begin
                if (!cond_ok) begin
                    out_valid <= 1'b1;
                end else if (!op_is_seq) begin
                    out_valid <= 1'b1;
                    out_we    <= res_we;
                    if (res_we)   result <= alu_res;
                    if (flag_upd) flags  <= new_flags;
                end
            end
`ifdef ALU_MUL_EN
            if (mul_last) begin
                out_valid <= 1'b1;
                out_we    <= 1'b1;
                result    <= acc_step;
                if (ms_q) begin
                    flags[FLAG_N] <= acc_step[WIDTH-1];
                    flags[FLAG_Z] <= (acc_step == '0);
                end
            end
`endif
            // Context restore overrides any same-edge flag update.
            if (flags_wr) flags <= flags_wdata;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with directed and randomized requests
module tb_alu_seq;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        s;
    logic [2:0]  srctrl;
    logic [4:0]  shamt;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [15:0] imvalue;
    logic        flags_wr;
    logic [3:0]  flags_wdata;
    logic        out_valid;
    logic        out_we;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_result;
    logic [3:0]  m_flags;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SHAMT_W(5), .IMM_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .cond(cond), .s(s), .srctrl(srctrl), .shamt(shamt),
        .in1(in1), .in2(in2), .imvalue(imvalue), .flags_wr(flags_wr),
        .flags_wdata(flags_wdata), .out_valid(out_valid), .out_we(out_we),
        .result(result), .flags(flags), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return 1'b1;
            1: return z;
            2: return !z;
            3: return cy;
            4: return !cy;
            5: return n;
            6: return !n;
            7: return v;
            8: return !v;
            9: return cy && !z;
            10: return !cy || z;
            11: return n == v;
            12: return n != v;
            13: return !z && (n == v);
            14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    task automatic shift_ref(input logic [2:0] sc, input int n, input logic [31:0] x,
                             output logic [31:0] y, output logic c, output logic cv);
        y  = x;
        c  = 1'b0;
        cv = (n != 0) && (sc >= 3'd1) && (sc <= 3'd4);
        if (n != 0) begin
            case (sc)
                3'd1: begin y = x << n; c = x[32-n]; end
                3'd2: begin y = x >> n; c = x[n-1]; end
                3'd3: begin y = 32'($signed(x) >>> n); c = x[n-1]; end
                3'd4: begin y = (x >> n) | (x << (32 - n)); c = y[31]; end
                default: ;
            endcase
        end
    endtask

    function automatic logic ovf(input longint v);
        return (v > 64'sd2147483647) || (v < -64'sd2147483648);
    endfunction

    task automatic issue(input logic [3:0] op, input logic [3:0] cnd, input logic sb,
                         input logic [2:0] sc, input logic [4:0] sa,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im,
                         input logic fw, input logic [3:0] fwd);
        logic        cok, shc, shcv, we, upd, is_mul, cy, v;
        logic [31:0] sh, val;
        logic [3:0]  nf;
        int          cyc, busy_bad;
        cok = cond_pass(cnd, m_flags);
        shift_ref(sc, int'(sa), b, sh, shc, shcv);
        val = 32'h0; we = 1'b0; upd = sb; is_mul = 1'b0;
        cy = shcv ? shc : m_flags[1];
        v  = m_flags[0];
        case (op)
            4'd0: begin
                val = a + sh; we = 1'b1;
                cy  = (longint'(a) + longint'(sh)) > 64'sd4294967295;
                v   = ovf(longint'($signed(a)) + longint'($signed(sh)));
            end
            4'd1, 4'd8: begin
                val = a - sh; we = (op == 4'd1); upd = sb || (op == 4'd8);
                cy  = a >= sh;
                v   = ovf(longint'($signed(a)) - longint'($signed(sh)));
            end
            4'd2: begin is_mul = MUL_EN; upd = 1'b0; end
            4'd3: begin val = a & sh; we = 1'b1; end
            4'd4: begin val = a | sh; we = 1'b1; end
            4'd5: begin val = a ^ sh; we = 1'b1; end
            4'd6: begin val = ~sh; we = 1'b1; end
            4'd7: begin val = sh; we = 1'b1; end
            4'd9: begin val = {16'h0, im}; we = 1'b1; cy = m_flags[1]; end
            4'd10: begin val = a & sh; upd = 1'b1; end
            default: upd = 1'b0;
        endcase
        if (!cok) begin we = 1'b0; upd = 1'b0; is_mul = 1'b0; end
        nf = upd ? {val[31], val == 32'h0, cy, v} : m_flags;

        opcode = op; cond = cnd; s = sb; srctrl = sc; shamt = sa;
        in1 = a; in2 = b; imvalue = im; flags_wr = fw; flags_wdata = fwd;
        in_valid = 1'b1;
        chk("ready_at_issue", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flags_wr = 1'b0;

        if (is_mul) begin
            m_flags = fw ? fwd : m_flags;
            cyc = 0; busy_bad = 0;
            // Keep a competing request asserted; it must be ignored while busy.
            opcode = 4'd0; in1 = $urandom; in2 = $urandom; in_valid = 1'b1;
            while (out_valid !== 1'b1 && cyc < 100) begin
                if (in_ready !== 1'b0 || busy !== 1'b1) busy_bad++;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 1'b0;
            chk("mul_latency", cyc, 32);
            chk("mul_busy_window", busy_bad, 0);
            val = a * sh;
            m_result = val;
            if (sb) m_flags = {val[31], val == 32'h0, m_flags[1:0]};
            chk("mul_out_valid", out_valid, 1);
            chk("mul_out_we", out_we, 1);
        end else begin
            if (we) m_result = val;
            m_flags = fw ? fwd : nf;
            chk("out_valid", out_valid, 1);
            chk("out_we", out_we, we);
        end
        chk("result", result, m_result);
        chk("flags", flags, m_flags);
        chk("ready_after", in_ready, 1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_we", out_we, 0);
        chk("idle_flags", flags, m_flags);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_we"}, out_we, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stray;
        logic [3:0] op;
        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'd15; cond = 4'd0; s = 1'b0;
        srctrl = 3'd0; shamt = 5'd0; in1 = 32'h0; in2 = 32'h0; imvalue = 16'h0;
        flags_wr = 1'b0; flags_wdata = 4'h0;
        m_result = 32'h0; m_flags = 4'h0;
        #12;
        check_reset_state("reset");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Arithmetic and overflow
        issue(4'd0, 4'd0, 1'b1, 3'd0, 5'd0, 32'd5, 32'd11, 16'h0, 1'b0, 4'h0);
        chk("add_5_11", result, 32'd16);
        issue(4'd0, 4'd0, 1'b1, 3'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0, 4'h0);
        chk("add_ovf_flags", flags, 4'b1001);
        // Conditions, back-to-back
        issue(4'd8, 4'd0, 1'b0, 3'd0, 5'd0, 32'd10, 32'd10, 16'h0, 1'b0, 4'h0);
        chk("cmp_eq_flags", flags, 4'b0110);
        issue(4'd0, 4'd1, 1'b0, 3'd0, 5'd0, 32'd10, 32'd10, 16'h0, 1'b0, 4'h0);
        chk("add_eq_result", result, 32'd20);
        issue(4'd0, 4'd2, 1'b0, 3'd0, 5'd0, 32'd1, 32'd1, 16'h0, 1'b0, 4'h0);
        chk("add_ne_skipped", result, 32'd20);
        idle();
        // Shifter
        issue(4'd7, 4'd0, 1'b1, 3'd1, 5'd1, 32'h0, 32'h8000_0001, 16'h0, 1'b0, 4'h0);
        chk("mov_lsl_flags", flags, 4'b0010);
        issue(4'd7, 4'd0, 1'b1, 3'd4, 5'd4, 32'h0, 32'h0000_000F, 16'h0, 1'b0, 4'h0);
        chk("mov_ror_result", result, 32'hF000_0000);
        chk("mov_ror_flags", flags, 4'b1010);
        // Multiply (NOP without the multiplier)
        issue(4'd2, 4'd0, 1'b1, 3'd0, 5'd0, 32'd7, 32'd6, 16'h0, 1'b0, 4'h0);
        idle();
        // Flag restore wins over CMP
        issue(4'd8, 4'd0, 1'b1, 3'd0, 5'd0, 32'd5, 32'd33, 16'h0, 1'b1, 4'b1111);
        chk("flags_wr_wins", flags, 4'b1111);
        issue(4'd15, 4'd0, 1'b1, 3'd0, 5'd0, 32'd0, 32'd0, 16'h0, 1'b0, 4'h0);
        issue(4'd9, 4'd15, 1'b1, 3'd0, 5'd0, 32'd0, 32'd0, 16'hBEEF, 1'b0, 4'h0);
        issue(4'd9, 4'd0, 1'b1, 3'd0, 5'd0, 32'd0, 32'd0, 16'h8001, 1'b0, 4'h0);
        issue(4'd1, 4'd0, 1'b1, 3'd3, 5'd31, 32'd0, 32'h8000_0000, 16'h0, 1'b0, 4'h0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                  1'($urandom), 3'($urandom), 5'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                  16'($urandom), ($urandom_range(0, 15) == 0), 4'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Reset in the middle of a long operation
        opcode = 4'd2; cond = 4'd0; s = 1'b1; srctrl = 3'd0; shamt = 5'd0;
        in1 = 32'd3; in2 = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check_reset_state("midreset");
        @(negedge clk) rst_n = 1'b1;
        m_flags = 4'h0; m_result = 32'h0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stray++;
        end
        chk("midreset_no_pulse", stray, 0);
        chk("midreset_ready", in_ready, 1);
        issue(4'd0, 4'd0, 1'b1, 3'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 4'h0);
        chk("post_reset_add_flags", flags, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the combinational 32-bit ALU. It holds the architectural NZCV flags register internally and evaluates condition codes against it. It applies a variable-amount barrel shift to operand 2 and runs an iterative shift-add multiply. The execute stage talks to it through a valid/ready request handshake and receives a one-cycle result pulse.

Parameters:
WIDTH, 32, datapath width (≥8)
SHAMT_W, 5, shift-amount width; must equal $clog2(WIDTH)
IMM_W, 16, immediate width (≤WIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
opcode  in  4  operation
cond  in  4  condition code
s  in  1  update flags when 1
srctrl  in  3  shift control applied to in2
shamt  in  SHAMT_W  shift amount
in1  in  WIDTH  operand 1
in2  in  WIDTH  operand 2
imvalue  in  IMM_W  immediate for MOVI
flags_wr  in  1  direct flags load (context restore)
flags_wdata  in  4  value for direct load, {N,Z,C,V}
out_valid  out  1  one-cycle completion pulse
out_we  out  1  with out_valid: result is to be written back
result  out  WIDTH  registered result
flags  out  4  flags register {N,Z,C,V}
busy  out  1  multiply in progress (= ~in_ready)

Behaviour:
- Reset (async, rst_n=0): flags=0, result=0, out_valid=0, out_we=0, FSM=IDLE, in_ready=1. Assertion mid-multiply aborts it; no out_valid is produced.
- Accept happens at the rising edge where in_valid & in_ready. There is no output back-pressure.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 NOT (~in2'), 7 MOV (in2').
  - 8 CMP (in1-in2', flags only), 9 MOVI (zero-extended imvalue), 10 TST (in1&in2', flags only).
  - 11-14 are reserved and act as NOP; 15 is NOP.
- Shift of in2 (result in2'):
  - srctrl 0 none, 1 LSL, 2 LSR, 3 ASR, 4 ROR, 5-7 none.
  - shamt=0 means no shift.
  - shifter carry = last bit shifted out.
- Conditions, evaluated on the flags register at accept:
  - 0 AL, 1 EQ, 2 NE, 3 CS, 4 CC, 5 MI, 6 PL, 7 VS, 8 VC.
  - 9 HI (C&~Z), 10 LS, 11 GE (N==V), 12 LT, 13 GT (~Z&N==V), 14 LE, 15 NV (never).
- Condition fails: out_valid=1 and out_we=0 next cycle; flags and result unchanged; MUL is not started.
- Single-cycle ops: result and flags are registered at the accept edge; out_valid=1 in the following cycle.
  - out_we=1 except for CMP, TST and NOP.
  - A back-to-back request sees the flags already updated.
- Flag rules (applied only when s=1; CMP/TST always update):
  - N = msb; Z = (value==0).
  - ADD: C = carry-out, V = signed overflow.
  - SUB/CMP: C = ~borrow, V = signed overflow.
  - Logic/MOV/NOT/TST: C = shifter carry if shamt≠0 and srctrl∈1..4, else unchanged; V unchanged.
  - MOVI: C and V unchanged.
  - MUL: N and Z updated; C and V unchanged.
  - NOP never changes flags.
- MUL FSM:
  - IDLE→MUL on accept; operands are latched and the counter is loaded with WIDTH-1.
  - Each cycle performs one shift-add step; the counter decrements.
  - MUL→IDLE at the edge where the counter reaches 0. That edge registers the low WIDTH bits of the product and the flags.
  - in_ready=0 from the accept edge through the final edge. out_valid=1 and in_ready=1 in the cycle after the final edge. Total WIDTH cycles from accept to result edge.
- flags_wr loads flags_wdata at any edge. If it coincides with an op's flag update, flags_wr wins.
- out_valid and out_we are low in every cycle without a completion.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 2 is the iterative multiply described above.
- Undefined:
  - No FSM or multiplier is built; in_ready and busy are tied to 1 and 0 respectively.
  - Opcode 2 behaves as NOP: out_valid=1 and out_we=0 next cycle; flags unchanged.

Decomposition:
- Package alu_pkg holds the opcode, cond and srctrl enumerations, the flag bit indices (N=3, Z=2, C=1, V=0), and the FSM state type.
- Sub-module alu_shifter (combinational, WIDTH/SHAMT_W parametrised) produces in2' and the shifter carry.
- The condition evaluator and the MUL FSM stay inline.

Test Plan:
1. Reset with WIDTH=32 → flags=0000, out_valid=0, result=0, in_ready=1; assert rst_n=0 mid-MUL → FSM returns to IDLE, no out_valid.
2. ADD in1=5 in2=11 s=1 → next cycle result=16, out_we=1, flags=0000; ADD 0x7FFFFFFF+1 → 0x80000000, flags=1001.
3. CMP 10,10 → flags=0110. Then ADD cond=EQ 10+10 → result=20, out_we=1. Then cond=NE → out_valid=1, out_we=0, result still 20.
4. MOV srctrl=LSL shamt=1 in2=0x80000001 s=1 → result=0x00000002, flags=0010. ROR shamt=4 in2=0x0000000F → 0xF0000000, flags=1010.
5. MUL 7×6 s=1 (ALU_MUL_EN defined) → in_ready=0 for 32 cycles with in_valid held high and ignored. Then result=42, out_we=1, flags N=Z=0, C/V preserved.
6. flags_wr=1 flags_wdata=1111 on the same edge as CMP 5,33 → flags=1111. MUL without ALU_MUL_EN → out_we=0, flags unchanged.
